// File: rtl/mor1kx_wb_mux_pipelined_if.sv
// Writeback-stage bus: issue-side controls and source data in, RF write port and stall out.
// The slave modport is the writeback stage itself; the master modport is the pipeline feeding it.
interface mor1kx_wb_mux_pipelined_if #(
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int OPTION_RF_ADDR_WIDTH = 5
);
   logic                            padv_i;
   logic                            pipeline_flush_i;
   logic                            rf_wb_i;
   logic [OPTION_RF_ADDR_WIDTH-1:0] rfd_adr_i;
   logic                            op_lsu_load_i;
   logic                            op_mfspr_i;
   logic                            op_jal_i;
   logic [OPTION_OPERAND_WIDTH-1:0] alu_result_i;
   logic                            alu_valid_i;
   logic [OPTION_OPERAND_WIDTH-1:0] lsu_result_i;
   logic                            lsu_valid_i;
   logic [OPTION_OPERAND_WIDTH-1:0] spr_i;
   logic [OPTION_OPERAND_WIDTH-1:0] pc_fetch_next_i;
   logic [OPTION_OPERAND_WIDTH-1:0] rf_result_o;
   logic [OPTION_RF_ADDR_WIDTH-1:0] rf_wb_adr_o;
   logic                            rf_we_o;
   logic                            wb_busy_o;

   modport master (
      output padv_i, pipeline_flush_i, rf_wb_i, rfd_adr_i,
      output op_lsu_load_i, op_mfspr_i, op_jal_i,
      output alu_result_i, alu_valid_i, lsu_result_i, lsu_valid_i,
      output spr_i, pc_fetch_next_i,
      input  rf_result_o, rf_wb_adr_o, rf_we_o, wb_busy_o
   );

   modport slave (
      input  padv_i, pipeline_flush_i, rf_wb_i, rfd_adr_i,
      input  op_lsu_load_i, op_mfspr_i, op_jal_i,
      input  alu_result_i, alu_valid_i, lsu_result_i, lsu_valid_i,
      input  spr_i, pc_fetch_next_i,
      output rf_result_o, rf_wb_adr_o, rf_we_o, wb_busy_o
   );
endinterface

// File: rtl/mor1kx_wb_mux_pipelined.sv
// Registered RF writeback mux: lsu > mfspr > jal > alu, waits for multi-cycle sources.
// Latency 1 cycle from issue (ready source) or from the source valid; wb_busy_o stalls issue while waiting.
module mor1kx_wb_mux_pipelined #(
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int OPTION_RF_ADDR_WIDTH = 5,
   parameter int OPTION_RF_R0_PROTECT = 1
) (
   input logic                     clk,
   input logic                     rst,
   mor1kx_wb_mux_pipelined_if.slave bus
);
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SRC_ALU = 2'd0,
      SRC_LSU = 2'd1,
      SRC_SPR = 2'd2,
      SRC_JAL = 2'd3
   } src_t;

   localparam logic R0_PROTECT = (OPTION_RF_R0_PROTECT != 0);

   state_t                            r_state;
   src_t                              r_src;
   logic [OPTION_OPERAND_WIDTH-1:0]   r_result;
   logic [OPTION_RF_ADDR_WIDTH-1:0]   r_adr;
   logic                              r_we;

   logic                              w_issue;
   src_t                              w_issue_src;
   logic                              w_issue_rdy;
   logic [OPTION_OPERAND_WIDTH-1:0]   w_issue_dat;
   logic                              w_issue_r0;
   logic                              w_wait_vld;
   logic [OPTION_OPERAND_WIDTH-1:0]   w_wait_dat;
   logic                              w_wait_r0;

   assign w_issue = bus.padv_i & bus.rf_wb_i & (r_state == ST_IDLE);

   // mfspr and jal data are valid at issue; only load and alu can be late.
   always_comb begin
      w_issue_src = SRC_ALU;
      w_issue_rdy = bus.alu_valid_i;
      w_issue_dat = bus.alu_result_i;
      if (bus.op_lsu_load_i) begin
         w_issue_src = SRC_LSU;
         w_issue_rdy = bus.lsu_valid_i;
         w_issue_dat = bus.lsu_result_i;
      end else if (bus.op_mfspr_i) begin
         w_issue_src = SRC_SPR;
         w_issue_rdy = 1'b1;
         w_issue_dat = bus.spr_i;
      end else if (bus.op_jal_i) begin
         w_issue_src = SRC_JAL;
         w_issue_rdy = 1'b1;
         w_issue_dat = bus.pc_fetch_next_i;
      end
   end

   // Only the latched source may complete a wait; the other valid is ignored.
   always_comb begin
      w_wait_vld = bus.alu_valid_i;
      w_wait_dat = bus.alu_result_i;
      if (r_src == SRC_LSU) begin
         w_wait_vld = bus.lsu_valid_i;
         w_wait_dat = bus.lsu_result_i;
      end
   end

   assign w_issue_r0 = R0_PROTECT && (bus.rfd_adr_i == '0);
   assign w_wait_r0  = R0_PROTECT && (r_adr == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_src    <= SRC_ALU;
         r_result <= '0;
         r_adr    <= '0;
         r_we     <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if (bus.pipeline_flush_i) begin
            r_state <= ST_IDLE;
         end else if (r_state == ST_IDLE) begin
            if (w_issue) begin
               r_src <= w_issue_src;
               r_adr <= bus.rfd_adr_i;
               if (w_issue_rdy) begin
                  if (!w_issue_r0) begin
                     r_result <= w_issue_dat;
                     r_we     <= 1'b1;
                  end
               end else begin
                  r_state <= ST_WAIT;
               end
            end
         end else begin
            if (w_wait_vld) begin
               r_state <= ST_IDLE;
               if (!w_wait_r0) begin
                  r_result <= w_wait_dat;
                  r_we     <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.rf_result_o = r_result;
   assign bus.rf_wb_adr_o = r_adr;
   assign bus.rf_we_o     = r_we;
   assign bus.wb_busy_o   = (r_state == ST_WAIT);
endmodule

// File: tb/tb_mor1kx_wb_mux_pipelined.sv
// Scoreboard bench: one DUT with R0 protection, one without, fed identical stimulus.
module tb_mor1kx_wb_mux_pipelined;
   localparam int W = 32;
   localparam int A = 5;

   typedef struct {
      logic [A-1:0] adr;
      logic [W-1:0] dat;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mor1kx_wb_mux_pipelined_if #(.OPTION_OPERAND_WIDTH(W), .OPTION_RF_ADDR_WIDTH(A)) ifc_p ();
   mor1kx_wb_mux_pipelined_if #(.OPTION_OPERAND_WIDTH(W), .OPTION_RF_ADDR_WIDTH(A)) ifc_n ();

   assign ifc_n.padv_i           = ifc_p.padv_i;
   assign ifc_n.pipeline_flush_i = ifc_p.pipeline_flush_i;
   assign ifc_n.rf_wb_i          = ifc_p.rf_wb_i;
   assign ifc_n.rfd_adr_i        = ifc_p.rfd_adr_i;
   assign ifc_n.op_lsu_load_i    = ifc_p.op_lsu_load_i;
   assign ifc_n.op_mfspr_i       = ifc_p.op_mfspr_i;
   assign ifc_n.op_jal_i         = ifc_p.op_jal_i;
   assign ifc_n.alu_result_i     = ifc_p.alu_result_i;
   assign ifc_n.alu_valid_i      = ifc_p.alu_valid_i;
   assign ifc_n.lsu_result_i     = ifc_p.lsu_result_i;
   assign ifc_n.lsu_valid_i      = ifc_p.lsu_valid_i;
   assign ifc_n.spr_i            = ifc_p.spr_i;
   assign ifc_n.pc_fetch_next_i  = ifc_p.pc_fetch_next_i;

   mor1kx_wb_mux_pipelined #(.OPTION_OPERAND_WIDTH(W), .OPTION_RF_ADDR_WIDTH(A),
                             .OPTION_RF_R0_PROTECT(1)) dut_p (.clk(clk), .rst(rst), .bus(ifc_p));
   mor1kx_wb_mux_pipelined #(.OPTION_OPERAND_WIDTH(W), .OPTION_RF_ADDR_WIDTH(A),
                             .OPTION_RF_R0_PROTECT(0)) dut_n (.clk(clk), .rst(rst), .bus(ifc_n));

   // Stimulus for the next edge.
   logic         s_rst, s_padv, s_flush, s_rfwb, s_ld, s_spr, s_jal, s_alu_v, s_lsu_v;
   logic [A-1:0] s_adr;
   logic [W-1:0] s_alu_d, s_lsu_d, s_spr_d, s_pc_d;

   // Reference model: one pending writeback per instance, plus the expected visible outputs.
   bit           m_act [2];
   bit           m_lsu [2];
   logic [A-1:0] m_adr [2];
   logic         nxt_we [2], cur_we [2];
   logic         nxt_busy [2], cur_busy [2];
   logic [W-1:0] nxt_res [2], cur_res [2];
   wr_t          wq0 [$];
   wr_t          wq1 [$];

   int  n_cmp  = 0;
   int  n_fail = 0;
   bit  chk_en = 0;

   task automatic cmp(input string name, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d at %0t: got %h expected %h", name, k, $time, act, exp);
      end
   endtask

   task automatic clr();
      s_rst = 0; s_padv = 0; s_flush = 0; s_rfwb = 0; s_ld = 0; s_spr = 0; s_jal = 0;
      s_alu_v = 0; s_lsu_v = 0; s_adr = '0;
      s_alu_d = '0; s_lsu_d = '0; s_spr_d = '0; s_pc_d = '0;
   endtask

   task automatic apply();
      rst                    = s_rst;
      ifc_p.padv_i           = s_padv;
      ifc_p.pipeline_flush_i = s_flush;
      ifc_p.rf_wb_i          = s_rfwb;
      ifc_p.rfd_adr_i        = s_adr;
      ifc_p.op_lsu_load_i    = s_ld;
      ifc_p.op_mfspr_i       = s_spr;
      ifc_p.op_jal_i         = s_jal;
      ifc_p.alu_result_i     = s_alu_d;
      ifc_p.alu_valid_i      = s_alu_v;
      ifc_p.lsu_result_i     = s_lsu_d;
      ifc_p.lsu_valid_i      = s_lsu_v;
      ifc_p.spr_i            = s_spr_d;
      ifc_p.pc_fetch_next_i  = s_pc_d;
   endtask

   task automatic complete(input int k, input logic [A-1:0] adr, input logic [W-1:0] d);
      wr_t e;
      if (k == 0 && adr == '0) return;
      nxt_we[k]  = 1'b1;
      nxt_res[k] = d;
      e.adr = adr;
      e.dat = d;
      if (k == 0) wq0.push_back(e);
      else        wq1.push_back(e);
   endtask

   task automatic model_eval();
      for (int k = 0; k < 2; k++) begin
         nxt_we[k] = 1'b0;
         if (s_rst) begin
            m_act[k] = 0;
            nxt_res[k] = '0;
         end else if (s_flush) begin
            m_act[k] = 0;
         end else if (m_act[k]) begin
            if (m_lsu[k] ? s_lsu_v : s_alu_v) begin
               m_act[k] = 0;
               complete(k, m_adr[k], m_lsu[k] ? s_lsu_d : s_alu_d);
            end
         end else if (s_padv && s_rfwb) begin
            if (s_ld) begin
               if (s_lsu_v) complete(k, s_adr, s_lsu_d);
               else begin m_act[k] = 1; m_lsu[k] = 1; m_adr[k] = s_adr; end
            end else if (s_spr) complete(k, s_adr, s_spr_d);
            else if (s_jal) complete(k, s_adr, s_pc_d);
            else if (s_alu_v) complete(k, s_adr, s_alu_d);
            else begin m_act[k] = 1; m_lsu[k] = 0; m_adr[k] = s_adr; end
         end
         nxt_busy[k] = m_act[k];
      end
   endtask

   // One clock: publish what the last edge should have produced, then drive the next inputs.
   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         cur_we[k]   = nxt_we[k];
         cur_busy[k] = nxt_busy[k];
         cur_res[k]  = nxt_res[k];
      end
      apply();
      model_eval();
   endtask

   task automatic check_inst(input int k);
      logic         we, busy;
      logic [W-1:0] res;
      logic [A-1:0] adr;
      wr_t          e;
      if (k == 0) begin
         we = ifc_p.rf_we_o; busy = ifc_p.wb_busy_o; res = ifc_p.rf_result_o; adr = ifc_p.rf_wb_adr_o;
      end else begin
         we = ifc_n.rf_we_o; busy = ifc_n.wb_busy_o; res = ifc_n.rf_result_o; adr = ifc_n.rf_wb_adr_o;
      end
      cmp("wb_busy", k, W'(busy), W'(cur_busy[k]));
      cmp("rf_we", k, W'(we), W'(cur_we[k]));
      cmp("rf_result", k, res, cur_res[k]);
      if (we === 1'b1) begin
         n_cmp++;
         if ((k == 0 ? wq0.size() : wq1.size()) == 0) begin
            n_fail++;
            $display("FAIL unexpected_write dut%0d at %0t: got adr %h data %h expected no write", k, $time, adr, res);
         end else begin
            e = (k == 0) ? wq0.pop_front() : wq1.pop_front();
            cmp("wb_adr", k, W'(adr), W'(e.adr));
            cmp("wb_data", k, res, e.dat);
         end
      end
      if (busy === 1'b1 && ifc_p.padv_i === 1'b1 && ifc_p.rf_wb_i === 1'b1) begin
         n_fail++;
         $display("FAIL issue_in_wait dut%0d at %0t: got padv&rf_wb=1 expected 0", k, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check_inst(0);
         check_inst(1);
      end
   end

   task automatic issue(input logic [A-1:0] adr);
      s_padv = 1; s_rfwb = 1; s_adr = adr;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_act[k] = 0; m_lsu[k] = 0; m_adr[k] = '0;
         nxt_we[k] = 0; nxt_busy[k] = 0; nxt_res[k] = '0;
         cur_we[k] = 0; cur_busy[k] = 0; cur_res[k] = '0;
      end
      clr(); s_rst = 1; apply(); model_eval();
      step();
      chk_en = 1;
      step();

      // alu ready at issue
      clr(); issue(5'd3); s_alu_v = 1; s_alu_d = 32'h1234; step();
      clr(); step(); step();

      // load + jal, load wins and arrives three cycles later; stray alu valid ignored
      clr(); issue(5'd4); s_ld = 1; s_jal = 1; s_pc_d = 32'h55; step();
      clr(); s_alu_v = 1; s_alu_d = 32'h1111; step();
      clr(); step();
      clr(); s_lsu_v = 1; s_lsu_d = 32'hDEADBEEF; step();
      clr(); step();

      // back-to-back mfspr then jal
      clr(); issue(5'd7); s_spr = 1; s_spr_d = 32'hA5; step();
      clr(); issue(5'd9); s_jal = 1; s_pc_d = 32'h100; step();
      clr(); step();

      // flush beats the valid that would finish a wait
      clr(); issue(5'd5); step();
      clr(); step();
      clr(); s_alu_v = 1; s_alu_d = 32'hBAD; s_flush = 1; step();
      clr(); step();

      // flush beats a ready issue
      clr(); issue(5'd6); s_alu_v = 1; s_alu_d = 32'hF00D; s_flush = 1; step();
      clr(); step();

      // writes to r0
      clr(); issue(5'd0); s_alu_v = 1; s_alu_d = 32'h77; step();
      clr(); step();
      clr(); issue(5'd0); s_ld = 1; step();
      clr(); s_lsu_v = 1; s_lsu_d = 32'h88; step();
      clr(); step();

      // reset while waiting drops the pending load
      clr(); issue(5'd6); s_ld = 1; step();
      clr(); step();
      clr(); s_rst = 1; step();
      clr(); s_lsu_v = 1; s_lsu_d = 32'h99; step();
      clr(); step(); step();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         clr();
         s_rst   = ($urandom_range(0, 199) == 0);
         s_flush = ($urandom_range(0, 15) == 0);
         s_padv  = ($urandom_range(0, 3) != 0);
         s_rfwb  = m_act[0] ? 1'b0 : ($urandom_range(0, 3) != 0);
         s_adr   = ($urandom_range(0, 7) == 0) ? 5'd0 : A'($urandom_range(0, 31));
         s_ld    = ($urandom_range(0, 3) == 0);
         s_spr   = ($urandom_range(0, 3) == 0);
         s_jal   = ($urandom_range(0, 3) == 0);
         s_alu_v = $urandom_range(0, 1) == 1;
         s_lsu_v = $urandom_range(0, 1) == 1;
         s_alu_d = $urandom;
         s_lsu_d = $urandom;
         s_spr_d = $urandom;
         s_pc_d  = $urandom;
         step();
      end

      clr(); s_flush = 1; step();
      clr(); step(); step(); step();
      chk_en = 0;

      cmp("drain_q0", 0, W'(wq0.size()), '0);
      cmp("drain_q1", 1, W'(wq1.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
